// File: rtl/hv_ngram_encoder_if.sv
// hv_ngram_encoder_if: stream, item-memory and result signals of one encoder lane
interface hv_ngram_encoder_if #(
  parameter int DIM    = 32,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
);
  logic [2:0]        cfg_n;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [DIM-1:0]    im_wdata;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic              in_last;
  logic [DIM-1:0]    tie_rand;
  logic              out_valid;
  logic              out_ready;
  logic [DIM-1:0]    out_hv;
  logic [CNT_W-1:0]  out_grams;
  logic              out_ovf;
  modport master (
    output cfg_n, im_we, im_waddr, im_wdata, in_valid, in_addr, in_last, tie_rand, out_ready,
    input  in_ready, out_valid, out_hv, out_grams, out_ovf
  );
  modport slave (
    input  cfg_n, im_we, im_waddr, im_wdata, in_valid, in_addr, in_last, tie_rand, out_ready,
    output in_ready, out_valid, out_hv, out_grams, out_ovf
  );
endinterface

// File: rtl/hv_ngram_encoder.sv
// hv_ngram_encoder: item memory lookup, sliding permute-XOR n-gram binding, saturating bundling and majority
module hv_ngram_encoder #(
  parameter int DIM       = 32,
  parameter int ADDR_W    = 10,
  parameter int NGRAM_MAX = 4,
  parameter int CNT_W     = 8
) (
  input logic clk,
  input logic rst,
  hv_ngram_encoder_if.slave bus
);
  localparam int NW = $clog2(NGRAM_MAX + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  typedef enum logic [1:0] {ACCUM, DRAIN, MAJ, OUT} state_t;
  state_t             r_state, w_next;
  logic               r_dcnt;
  logic [DIM-1:0]     r_mem [2**ADDR_W];
  logic [DIM-1:0]     r_rd_data;
  logic               r_rd_v;
  logic               r_started;
  logic [2:0]         r_n;
  logic [NW-1:0]      r_nvec;
  logic [DIM-1:0]     r_win [NGRAM_MAX];
  logic [DIM-1:0]     w_slot [NGRAM_MAX];
  logic [DIM-1:0]     w_gram;
  logic               w_gvalid;
  logic               r_g_v;
  logic [DIM-1:0]     r_gram;
  logic [CNT_W-1:0]   r_cnt [DIM];
  logic [CNT_W-1:0]   r_gcnt;
  logic               r_ovf;
  logic [DIM-1:0]     w_maj;
  logic [DIM-1:0]     r_hv;
  logic [2:0]         w_n_in;
  logic               w_xfer;
  logic               w_clr;
  assign w_xfer = bus.in_valid & bus.in_ready;
  assign w_clr  = (r_state == OUT) & bus.out_ready;
  assign w_n_in = (bus.cfg_n == 3'd0 || 32'(bus.cfg_n) > NGRAM_MAX) ? 3'd1 : bus.cfg_n;
  // item memory: write port plus registered read that returns old data on a same-address write
  always_ff @(posedge clk) begin
    if (bus.im_we) r_mem[bus.im_waddr] <= bus.im_wdata;
    r_rd_data <= r_mem[bus.in_addr];
  end
  // read-valid tag, per-sequence N latch and count of vectors that have entered the window
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_rd_v    <= 1'b0;
      r_started <= 1'b0;
      r_n       <= 3'd1;
      r_nvec    <= '0;
    end else begin
      r_rd_v <= w_xfer;
      if (w_xfer && !r_started) begin
        r_started <= 1'b1;
        r_n       <= w_n_in;
      end
      if (r_rd_v && 32'(r_nvec) < NGRAM_MAX) r_nvec <= r_nvec + 1'b1;
    end
  end
  assign w_slot[0] = r_rd_data;
  for (genvar k = 1; k < NGRAM_MAX; k++) begin : g_slot
    assign w_slot[k] = r_win[k-1];
  end
  // window shift: the freshly read vector becomes slot 0
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      for (int k = 0; k < NGRAM_MAX; k++) r_win[k] <= '0;
    end else if (r_rd_v) begin
      for (int k = 0; k < NGRAM_MAX; k++) r_win[k] <= w_slot[k];
    end
  end
  // bind: slot k is rotated left by k, only the first n_eff slots take part
  always_comb begin
    w_gram = '0;
    for (int k = 0; k < NGRAM_MAX; k++)
      if (k < 32'(r_n)) w_gram = w_gram ^ ((w_slot[k] << k) | (w_slot[k] >> (DIM - k)));
    w_gvalid = r_rd_v && (32'(r_nvec) + 1 >= 32'(r_n));
  end
  // gram register feeding the bundle stage
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_g_v  <= 1'b0;
      r_gram <= '0;
    end else begin
      r_g_v  <= w_gvalid;
      r_gram <= w_gram;
    end
  end
  // saturating bundle counters; a gram arriving at a full gram count is dropped whole
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      for (int d = 0; d < DIM; d++) r_cnt[d] <= '0;
      r_gcnt <= '0;
      r_ovf  <= 1'b0;
    end else if (r_g_v) begin
      if (r_gcnt == CMAX) r_ovf <= 1'b1;
      else begin
        r_gcnt <= r_gcnt + 1'b1;
        for (int d = 0; d < DIM; d++)
          if (r_gram[d]) begin
            if (r_cnt[d] == CMAX) r_ovf <= 1'b1;
            else r_cnt[d] <= r_cnt[d] + 1'b1;
          end
      end
    end
  end
  // majority against half the gram count, ties resolved by the random vector
  always_comb begin
    w_maj = '0;
    for (int d = 0; d < DIM; d++)
      w_maj[d] = ({r_cnt[d], 1'b0} > {1'b0, r_gcnt}) ? 1'b1 :
                 ({r_cnt[d], 1'b0} < {1'b0, r_gcnt}) ? 1'b0 : bus.tie_rand[d];
  end
  // result register captured in MAJ and held through OUT
  always_ff @(posedge clk) begin
    if (rst) r_hv <= '0;
    else if (r_state == MAJ) r_hv <= w_maj;
  end
  // state register and two-cycle drain timer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
      r_dcnt  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dcnt  <= (r_state == DRAIN) ? ~r_dcnt : 1'b0;
    end
  end
  // next-state logic
  always_comb begin
    w_next = (r_state == ACCUM) ? ((w_xfer && bus.in_last) ? DRAIN : ACCUM) :
             (r_state == DRAIN) ? (r_dcnt ? MAJ : DRAIN) :
             (r_state == MAJ)   ? OUT :
                                  (bus.out_ready ? ACCUM : OUT);
  end
  // handshake outputs decoded from state
  always_comb begin
    bus.in_ready  = (r_state == ACCUM);
    bus.out_valid = (r_state == OUT);
  end
  assign bus.out_hv    = r_hv;
  assign bus.out_grams = r_gcnt;
  assign bus.out_ovf   = r_ovf;
endmodule

// File: doc/hv_ngram_encoder.md
Name: hv_ngram_encoder

Overview:
Parametrised successor to the fixed 32-bit, fixed-3-gram encode core. It holds a local item memory and takes a stream of item addresses. It forms sliding-window N-grams by permute-and-XOR binding, with N selectable at runtime, and bundles them in per-dimension saturating counters. On sequence end it emits the majority hypervector, with ties broken by an external random vector. One instance sits per core lane between the input stream demux and the output buffer controller.

Parameters:
DIM, 32, hypervector width in bits
ADDR_W, 10, item memory address width (depth = 2**ADDR_W)
NGRAM_MAX, 4, largest supported N (>=1)
CNT_W, 8, bundling counter width; also the width of the gram counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_n  in  3  N-gram size; sampled at the first accepted address of a sequence
im_we  in  1  item memory write enable
im_waddr  in  ADDR_W  item memory write address
im_wdata  in  DIM  item memory write data (PRNG output during generation)
in_valid  in  1  address valid
in_ready  out  1  encoder can accept an address
in_addr  in  ADDR_W  item address
in_last  in  1  last address of the sequence
tie_rand  in  DIM  tie-break vector, sampled when majority is computed
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_hv  out  DIM  bundled hypervector
out_grams  out  CNT_W  number of grams bundled
out_ovf  out  1  a counter saturated during this sequence

Behaviour:
- Reset values: rst clears all state. in_ready=1, out_valid=0, out_hv=0, out_grams=0, out_ovf=0. Counters and the window are cleared. Item memory contents are not reset.
- Clock/reset: one clock (clk); reset is synchronous and active-high (rst). A reset mid-sequence or mid-output discards everything; no output is produced.
- Item memory:
  - Synchronous write.
  - Synchronous read with 1-cycle latency.
  - Read-during-write to the same address returns the old data.
  - Writes are legal in any state.
- States:
  - ACCUM: in_ready=1. A transfer occurs on in_valid & in_ready. in_last on an accepted transfer moves to DRAIN.
  - DRAIN: in_ready=0. Held for exactly 2 cycles to flush the read and bundle stages, then moves to MAJ.
  - MAJ: 1 cycle. Computes the result into out_hv, then moves to OUT.
  - OUT: out_valid=1, held stable until out_ready. On out_valid & out_ready: clear counters, window and gram count, then return to ACCUM.
- Effective N (n_eff):
  - n_eff = cfg_n latched at the first transfer of a sequence.
  - cfg_n=0 or cfg_n>NGRAM_MAX gives n_eff=1.
  - Changes to cfg_n mid-sequence are ignored.
- Pipeline timing:
  - Transfer in cycle t: IM data is available in t+1 and shifts into a window of NGRAM_MAX vectors. Window slot 0 is the newest.
  - Gram = XOR over k=0..n_eff-1 of rotl(slot k, k). The newest vector is unrotated; the oldest is rotated left by n_eff-1.
  - Gram formation is gated: a gram is formed only once at least n_eff vectors have entered since the sequence start (sliding window, one gram per address thereafter).
  - The gram is registered into the bundle stage at the end of t+1. Counters update at the end of t+2.
- Bundling:
  - cnt[d] += gram[d]; gram_cnt += 1.
  - Each cnt[d] and gram_cnt saturates at 2**CNT_W-1. Once gram_cnt saturates, further grams are dropped entirely and out_ovf=1.
  - Saturation of any cnt[d] also sets out_ovf.
- Majority in MAJ, per bit d:
  - 2*cnt[d] > gram_cnt gives 1.
  - 2*cnt[d] < gram_cnt gives 0.
  - Equality gives tie_rand[d].
  - Compare at CNT_W+1 bits.
- Boundary cases:
  - Fewer than n_eff addresses gives gram_cnt=0, so out_hv = tie_rand and out_grams=0.
  - A single-address sequence with in_last is legal.
- out_grams = gram_cnt, held during OUT.

Test Plan:
- N=1 majority: IM[0]=0x0000FFFF, IM[1]=0x00FF00FF, IM[2]=0x0F0F0F0F, stream 0,1,2(last) -> out_hv=0x000F0FFF, out_grams=3, out_ovf=0.
- N=2 bind: same IM, stream 0,1(last), cfg_n=2 -> one gram rotl(0x0000FFFF,1)^0x00FF00FF -> out_hv=0x00FEFF01, out_grams=1.
- Ties: N=1, stream 0,1(last). tie_rand=0xFFFFFFFF -> out_hv=0x00FFFFFF. Repeat with tie_rand=0 -> out_hv=0x000000FF, out_grams=2.
- Short sequence and cfg change: cfg_n=3, stream 0,1(last), tie_rand=0xA5A5A5A5 -> out_hv=0xA5A5A5A5, out_grams=0. Change cfg_n to 1 mid-sequence of a 3-gram run -> result unchanged from the N=3 expectation.
- Backpressure and reset: hold out_ready=0 for 5 cycles -> out_valid and out_hv stable, in_ready=0 throughout. Assert rst in DRAIN -> next cycle out_valid=0, in_ready=1, and a following N=1 stream 2(last) gives 0x0F0F0F0F.
- Saturation (CNT_W=4): N=1, 20 transfers of address 0, then last -> out_grams=15, out_ovf=1, out_hv=0x0000FFFF.
